// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t : controller states (IDLE, COMPARE, DONE)
//   RES_*   : 3-bit result encoding, ordered {eq, lt, gt}
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
//   a, b : digit operands
//   gt   : a > b
//   lt   : a < b   (neither set means the digits are equal)
module cmp_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial magnitude comparator: compares two WIDTH-bit operands DIGIT bits
// per cycle, MSB digit first, stopping at the first differing digit.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   start             : request; accepted in IDLE or DONE, ignored in COMPARE
//   A, B, is_signed   : operands and mode, captured on accept
//   busy              : high while in COMPARE
//   done              : one-cycle pulse (the DONE state) after flags update
//   A_eq_B/lt/gt      : registered result, held until the next completion
//   o_dbg_state       : current controller state (state_t encoding)
//
// Handshake: start is a request that is accepted on any rising edge where
// busy=0; there is no back-pressure on the result, done is a pulse and the
// flags stay valid until the next done.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIGIT     = 1,
  parameter int SIGNED_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             A_eq_B,
  output logic             A_lt_B,
  output logic             A_gt_B,
  output logic [1:0]       o_dbg_state
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW   = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0]    LAST_IDX = IW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic [2:0]       r_flags;

  logic             w_accept;
  logic             w_sign;
  logic [WIDTH-1:0] w_mask;
  logic [SW-1:0]    w_rshift;
  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_gt;
  logic             w_lt;
  logic             w_last;
  logic             w_finish;
  logic [2:0]       w_result;

  assign w_accept = start && (r_state != COMPARE);

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the digit compare itself never needs to know about signedness.
  assign w_sign = is_signed && (SIGNED_EN != 0);
  assign w_mask = w_sign ? MSB_MASK : '0;

  // Right-shift the current digit down to bit 0; digit 0 is the MSB digit.
  assign w_rshift = SW'(WIDTH - DIGIT) - (SW'(r_idx) * SW'(DIGIT));
  assign w_da     = DIGIT'(r_a >> w_rshift);
  assign w_db     = DIGIT'(r_b >> w_rshift);

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (w_da),
    .b  (w_db),
    .gt (w_gt),
    .lt (w_lt)
  );

  assign w_last   = (r_idx == LAST_IDX);
  assign w_finish = w_gt || w_lt || w_last;
  assign w_result = w_gt ? RES_GT : (w_lt ? RES_LT : RES_EQ);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = COMPARE;
      COMPARE: if (w_finish) w_next = DONE;
      DONE:    w_next = start ? COMPARE : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    o_dbg_state = r_state;
    case (r_state)
      COMPARE: busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, digit index and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_flags <= RES_NONE;
    end else if (w_accept) begin
      r_a   <= A ^ w_mask;
      r_b   <= B ^ w_mask;
      r_idx <= '0;
    end else if (r_state == COMPARE) begin
      if (w_finish) begin
        r_flags <= w_result;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign {A_eq_B, A_lt_B, A_gt_B} = r_flags;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: a bit-serial instance (WIDTH=8,
// DIGIT=1, signed enabled) and a nibble-serial instance (WIDTH=8, DIGIT=4,
// signed disabled). Drivers push {eq,lt,gt,latency} into per-instance
// expected queues; monitors pop and compare whenever done is seen.
module tb_serial_magnitude_comparator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1: WIDTH=8, DIGIT=1 ----------------
  logic       start, is_signed, busy, done, eq, lt, gt;
  logic [7:0] a, b;
  logic [1:0] st;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(1), .SIGNED_EN(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .is_signed(is_signed),
    .busy(busy), .done(done), .A_eq_B(eq), .A_lt_B(lt), .A_gt_B(gt),
    .o_dbg_state(st)
  );

  // ---------------- DUT 2: WIDTH=8, DIGIT=4, unsigned only ----------------
  logic       start4, is_signed4, busy4, done4, eq4, lt4, gt4;
  logic [7:0] a4, b4;
  logic [1:0] st4;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(4), .SIGNED_EN(0)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .is_signed(is_signed4),
    .busy(busy4), .done(done4), .A_eq_B(eq4), .A_lt_B(lt4), .A_gt_B(gt4),
    .o_dbg_state(st4)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  logic [10:0] exp4_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [2:0]  last_flags = 3'b000;

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor DUT 1: latency = number of cycles spent busy before done.
  initial begin
    int          lat = 0;
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0;
      end else begin
        if (busy) lat++;
        if (done) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done: got flags %b, expected no done", {eq, lt, gt});
          end else begin
            e = exp_q.pop_front();
            chk("result", {eq, lt, gt, 8'(lat)}, e);
          end
          lat = 0;
        end
      end
    end
  end

  // Monitor DUT 2
  initial begin
    int          lat = 0;
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        lat = 0;
      end else begin
        if (busy4) lat++;
        if (done4) begin
          if (exp4_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_done4: got flags %b, expected no done", {eq4, lt4, gt4});
          end else begin
            e = exp4_q.pop_front();
            chk("result4", {eq4, lt4, gt4, 8'(lat)}, e);
          end
          lat = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no done, expected done within 40 cycles", name);
    end
  endtask

  task automatic run(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                     input logic [2:0] ef, input int el);
    @(negedge clk);
    a = va; b = vb; is_signed = vs; start = 1'b1;
    exp_q.push_back({ef, 8'(el)});
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs after capture; the running compare must not see them.
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    is_signed = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("flags_hold", {8'd0, eq, lt, gt}, {8'd0, last_flags});
    wait_done("run");
    last_flags = ef;
  endtask

  task automatic run4(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                      input logic [2:0] ef, input int el);
    int k = 0;
    @(negedge clk);
    a4 = va; b4 = vb; is_signed4 = vs; start4 = 1'b1;
    exp4_q.push_back({ef, 8'(el)});
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4 = 8'($urandom_range(0, 255));
    b4 = 8'($urandom_range(0, 255));
    @(negedge clk);
    while (!done4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done4) begin
      n_vec++; n_err++;
      $display("FAIL run4_timeout: got no done, expected done within 40 cycles");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start = 0; a = 0; b = 0; is_signed = 0;
    start4 = 0; a4 = 0; b4 = 0; is_signed4 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {6'd0, st, busy, done, eq, lt, gt}, 11'd0);
    rst = 1'b0;

    // Directed vectors: {eq,lt,gt}, cycles in COMPARE
    run(8'h00, 8'h00, 1'b0, 3'b100, 8);   // equal -> full length
    run(8'h80, 8'h7F, 1'b0, 3'b001, 1);   // unsigned, MSB differs
    run(8'h80, 8'h7F, 1'b1, 3'b010, 1);   // signed: -128 < 127
    run(8'h12, 8'h13, 1'b0, 3'b010, 8);   // LSB differs
    run(8'h13, 8'h12, 1'b0, 3'b001, 8);
    run(8'hA0, 8'h90, 1'b0, 3'b001, 3);   // first difference at bit 5
    run(8'hFF, 8'h01, 1'b1, 3'b010, 1);   // signed: -1 < 1
    run(8'h05, 8'hFB, 1'b1, 3'b001, 1);   // signed: 5 > -5
    run(8'hFE, 8'hFF, 1'b1, 3'b010, 8);   // signed: -2 < -1
    run(8'h7F, 8'h7F, 1'b1, 3'b100, 8);   // signed equal

    // Reset in the middle of a comparison: abort, no done pulse
    @(negedge clk);
    a = 8'h00; b = 8'h00; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_abort", {6'd0, st, busy, done, eq, lt, gt}, 11'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_flags = 3'b000;
    run(8'h13, 8'h12, 1'b0, 3'b001, 8);   // accepted right after reset

    // Back-to-back: start held through DONE with a new pair waiting
    @(negedge clk);
    a = 8'h12; b = 8'h13; is_signed = 1'b0; start = 1'b1;
    exp_q.push_back({3'b010, 8'd8});
    @(posedge clk);
    #1;
    a = 8'hFF; b = 8'hFE;
    exp_q.push_back({3'b001, 8'd8});
    wait_done("b2b_first");
    @(negedge clk);
    chk("b2b_no_idle", {10'd0, busy}, {10'd0, 1'b1});
    chk("b2b_flags_hold", {8'd0, eq, lt, gt}, {8'd0, 3'b010});
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom_range(0, 1));   // ignored while busy
      a = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    start = 1'b0;
    wait_done("b2b_second");
    last_flags = 3'b001;

    // Nibble-serial instance, signed mode disabled
    run4(8'h3C, 8'h3D, 1'b0, 3'b010, 2);
    run4(8'h5A, 8'h3A, 1'b0, 3'b001, 1);
    run4(8'h80, 8'h7F, 1'b1, 3'b001, 1);  // is_signed ignored
    run4(8'hC3, 8'hC3, 1'b0, 3'b100, 2);

    // Drain and check nothing is left outstanding
    repeat (4) @(negedge clk);
    chk("queue_empty", 11'(exp_q.size() + exp4_q.size()), 11'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, giving the bits compared per cycle; WIDTH mod DIGIT = 0 is required.
REQ-003 The block SHALL have parameter SIGNED_EN, default 1; when 0, is_signed is ignored and treated as 0.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port clk  input  1  sole clock, rising-edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  1  request a comparison; sampled on the rising edge.
REQ-008 Port A  input  WIDTH  first operand, captured on start accept.
REQ-009 Port B  input  WIDTH  second operand, captured on start accept.
REQ-010 Port is_signed  input  1  1 = two's-complement compare, 0 = unsigned; captured on start accept.
REQ-011 Port busy  output  1  high while in state COMPARE.
REQ-012 Port done  output  1  one-cycle pulse when a result is written.
REQ-013 Port A_eq_B  output  1  registered result, A equals B.
REQ-014 Port A_lt_B  output  1  registered result, A less than B.
REQ-015 Port A_gt_B  output  1  registered result, A greater than B.

Function
REQ-016 The FSM SHALL have states IDLE, COMPARE and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL capture A, B and is_signed, clear the digit index to 0 (MSB digit) and enter COMPARE.
REQ-018 In COMPARE, start SHALL be ignored; busy=1.
REQ-019 Each COMPARE edge SHALL compare captured digit [WIDTH-1-i*DIGIT -: DIGIT]; on mismatch or last digit (i = WIDTH/DIGIT-1) it SHALL write the flags, set done=1 and enter DONE; otherwise i increments.
REQ-020 Early termination: with the first differing digit at index d, done SHALL be high after start-accept edge + (d+1) edges; with equal operands it SHALL be high after WIDTH/DIGIT edges.
REQ-021 Signed mode SHALL invert bit WIDTH-1 of both captured operands before comparing; all other bits compare unsigned.
REQ-022 After the first completion, exactly one of A_eq_B, A_lt_B and A_gt_B SHALL be 1.
REQ-023 The flags SHALL hold their value until the next completion, unchanged by start or COMPARE.
REQ-024 DONE SHALL last one cycle, then go to IDLE, or to COMPARE if start=1 (back-to-back, no idle cycle).
REQ-025 Input changes on A, B or is_signed after capture SHALL have no effect on the running comparison.
REQ-026 The WIDTH=DIGIT case SHALL complete in exactly 1 COMPARE edge.

Reset
REQ-027 rst=1 SHALL immediately force the state to IDLE, busy=0, done=0, A_eq_B=0, A_lt_B=0, A_gt_B=0, digit index=0 and operand registers=0.
REQ-028 rst asserted mid-COMPARE SHALL abort the comparison with no done pulse.
REQ-029 On the first edge after rst deasserts, the block SHALL accept start normally.

Structure
REQ-030 Shared package cmp_pkg SHALL hold the state enum (IDLE, COMPARE, DONE) and the 3-bit result encoding {eq, lt, gt}.
REQ-031 One combinational sub-module, cmp_digit (DIGIT-bit inputs a and b, outputs gt and lt), SHALL perform the per-digit compare; the FSM, index counter and registers SHALL live in the top module.

Verification (WIDTH=8, DIGIT=1, SIGNED_EN=1 unless stated)
REQ-032 A=8'h00, B=8'h00, unsigned -> done after 8 edges, A_eq_B=1, others 0.
REQ-033 A=8'h80, B=8'h7F, unsigned -> done after 1 edge, A_gt_B=1; same operands signed -> done after 1 edge, A_lt_B=1.
REQ-034 A=8'h12, B=8'h13, unsigned -> done after 8 edges, A_lt_B=1; A=8'h13, B=8'h12 -> A_gt_B=1.
REQ-035 Reset asserted at COMPARE edge 3 of A=8'h00, B=8'h00 -> all outputs 0, no done pulse; a new start then completes normally.
REQ-036 start held high across DONE with a second pair A=8'hFF, B=8'hFE -> second comparison begins with no idle cycle, A_gt_B=1 after 8 edges; start pulses during busy are ignored.
REQ-037 WIDTH=8, DIGIT=4, A=8'h3C, B=8'h3D, unsigned -> done after 2 edges, A_lt_B=1.
